// File: rtl/countdown_sequencer_if.sv
// countdown_sequencer_if: switch value, request/ack handshake and display outputs of the countdown sequencer
interface countdown_sequencer_if #(parameter int WIDTH = 6);
    logic [WIDTH-1:0] set_val;
    logic start_req, pause_req, restart_req, clear_req;
    logic start_ack, pause_ack, restart_ack, clear_ack;
    logic [WIDTH-1:0] count;
    logic led;
    logic [2:0] state;
    modport master (
        output set_val, start_req, pause_req, restart_req, clear_req,
        input  start_ack, pause_ack, restart_ack, clear_ack, count, led, state
    );
    modport slave (
        input  set_val, start_req, pause_req, restart_req, clear_req,
        output start_ack, pause_ack, restart_ack, clear_ack, count, led, state
    );
endinterface

// File: rtl/countdown_sequencer.sv
// countdown_sequencer: control FSM that loads, decrements, pauses and reloads a count and blinks an expiry LED
module countdown_sequencer #(
    parameter int WIDTH       = 6,
    parameter int ALARM_TICKS = 10
) (
    input logic                    newclk,
    input logic                    my_reset,
    countdown_sequencer_if.slave   bus
);
    localparam int AW = (ALARM_TICKS < 1) ? 1 : $clog2(ALARM_TICKS + 1);
    localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_TICKS);

    typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, PAUSE = 3'd2, EXPIRED = 3'd3} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, first_q, first_d;
    logic             led_q, led_d;
    logic [AW-1:0]    alarm_q, alarm_d;
    logic [3:0]       ack_q, ack_d;
    logic [3:0]       eff;
    logic             do_clear, do_restart, do_pause, do_start;
    logic             blinking;

    // request arbitration, next-state and datapath updates for one step
    always_comb begin
        eff        = {bus.clear_req, bus.restart_req, bus.pause_req, bus.start_req} & ~ack_q;
        do_clear   = eff[3];
        do_restart = eff[2] & ~eff[3];
        do_pause   = eff[1] & ~|eff[3:2];
        do_start   = eff[0] & ~|eff[3:1];
        ack_d      = {do_clear, do_restart, do_pause, do_start};
        blinking   = alarm_q < ALARM_MAX;
        state_d    = state_q;
        count_d    = count_q;
        first_d    = first_q;
        led_d      = led_q;
        alarm_d    = alarm_q;
        if (state_q == EXPIRED) begin
            count_d = '0;
            led_d   = blinking ? ~led_q : 1'b1;
            alarm_d = blinking ? alarm_q + 1'b1 : alarm_q;
        end
        if (do_clear) begin
            state_d = IDLE;
            count_d = bus.set_val;
            led_d   = 1'b0;
            alarm_d = '0;
        end else if (do_restart && state_q != IDLE) begin
            state_d = (first_q == '0) ? EXPIRED : RUN;
            count_d = first_q;
            led_d   = 1'b0;
            alarm_d = '0;
        end else if (do_start && (state_q == IDLE || state_q == EXPIRED)) begin
            state_d = (bus.set_val == '0) ? EXPIRED : RUN;
            first_d = bus.set_val;
            count_d = bus.set_val;
            led_d   = 1'b0;
            alarm_d = '0;
        end else if (do_start && state_q == PAUSE) begin
            state_d = RUN;
        end else if (do_pause && state_q == RUN) begin
            state_d = PAUSE;
        end else if (state_q == RUN) begin
            count_d = (count_q == '0) ? '0 : count_q - 1'b1;
            state_d = (count_q <= WIDTH'(1)) ? EXPIRED : RUN;
            alarm_d = '0;
        end else if (state_q == IDLE) begin
            count_d = bus.set_val;
        end
    end

    // state and datapath registers with asynchronous reset
    always_ff @(posedge newclk or posedge my_reset) begin
        if (my_reset) begin
            state_q <= IDLE;
            count_q <= '0;
            first_q <= '0;
            led_q   <= 1'b0;
            alarm_q <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            first_q <= first_d;
            led_q   <= led_d;
            alarm_q <= alarm_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.clear_ack   = ack_q[3];
    assign bus.restart_ack = ack_q[2];
    assign bus.pause_ack   = ack_q[1];
    assign bus.start_ack   = ack_q[0];
    assign bus.count       = count_q;
    assign bus.led         = led_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_countdown_sequencer.sv
// tb_countdown_sequencer: directed and random steps checked against a tick-level behavioural model
module tb_countdown_sequencer;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_EXP = 3;

    logic newclk = 1'b0;
    logic my_reset;
    int   tests = 0;
    int   fails = 0;

    int         m_st, m_cnt, m_first, m_age;
    logic [3:0] m_ack;

    countdown_sequencer_if #(.WIDTH(6)) bus();

    countdown_sequencer #(.WIDTH(6), .ALARM_TICKS(10)) dut (
        .newclk  (newclk),
        .my_reset(my_reset),
        .bus     (bus)
    );

    always #5 newclk = ~newclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int m_led();
        if (m_st != ST_EXP || m_age == 0) return 0;
        if (m_age <= 10) return m_age % 2;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = ST_IDLE; m_cnt = 0; m_first = 0; m_age = 0; m_ack = 4'b0;
    endtask

    task automatic model_load(input int v);
        m_cnt = v;
        m_st  = (v == 0) ? ST_EXP : ST_RUN;
        m_age = 0;
    endtask

    task automatic model_step();
        logic [3:0] eff;
        eff   = {bus.clear_req, bus.restart_req, bus.pause_req, bus.start_req} & ~m_ack;
        m_ack = eff[3] ? 4'b1000 : eff[2] ? 4'b0100 : eff[1] ? 4'b0010 : eff[0] ? 4'b0001 : 4'b0000;
        if (m_ack[3]) begin
            m_st = ST_IDLE; m_cnt = int'(bus.set_val); m_age = 0;
        end else if (m_ack[2] && m_st != ST_IDLE) begin
            model_load(m_first);
        end else if (m_ack[0] && (m_st == ST_IDLE || m_st == ST_EXP)) begin
            m_first = int'(bus.set_val);
            model_load(m_first);
        end else if (m_ack[0] && m_st == ST_PAUSE) begin
            m_st = ST_RUN;
        end else if (m_ack[1] && m_st == ST_RUN) begin
            m_st = ST_PAUSE;
        end else if (m_st == ST_RUN) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin m_st = ST_EXP; m_age = 0; end
        end else if (m_st == ST_IDLE) begin
            m_cnt = int'(bus.set_val);
        end else if (m_st == ST_EXP && m_age < 100) begin
            m_age++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge newclk);
        #1;
        chk("state", 32'(bus.state), 32'(m_st));
        chk("count", 32'(bus.count), 32'(m_cnt));
        chk("led", 32'(bus.led), 32'(m_led()));
        chk("acks", 32'({bus.clear_ack, bus.restart_ack, bus.pause_ack, bus.start_ack}), 32'(m_ack));
        if (bus.start_ack)   bus.start_req   = 1'b0;
        if (bus.pause_ack)   bus.pause_req   = 1'b0;
        if (bus.restart_ack) bus.restart_req = 1'b0;
        if (bus.clear_ack)   bus.clear_req   = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 70 && m_cnt != target; i++) tick();
        chk("run_to_count", 32'(bus.count), 32'(target));
    endtask

    task automatic check_reset_values();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_led", 32'(bus.led), 32'd0);
        chk("rst_acks", 32'({bus.clear_ack, bus.restart_ack, bus.pause_ack, bus.start_ack}), 32'd0);
    endtask

    initial begin
        my_reset = 1'b1;
        bus.set_val = '0;
        bus.start_req = 1'b0; bus.pause_req = 1'b0; bus.restart_req = 1'b0; bus.clear_req = 1'b0;
        model_reset();
        #3;
        check_reset_values();
        @(posedge newclk); #1;
        my_reset = 1'b0;

        // T1: load 5, count down to expiry, blink then steady LED
        bus.set_val = 6'd5;
        tick();
        bus.start_req = 1'b1;
        tick();
        chk("t1_loaded", 32'(bus.count), 32'd5);
        ticks(5);
        chk("t1_expired_state", 32'(bus.state), 32'd3);
        chk("t1_expired_count", 32'(bus.count), 32'd0);
        ticks(12);
        chk("t1_led_steady", 32'(bus.led), 32'd1);

        // T2: pause at 12 for 8 ticks, resume without reload
        bus.clear_req = 1'b1;
        tick();
        bus.set_val = 6'd20;
        bus.start_req = 1'b1;
        tick();
        run_to(12);
        bus.pause_req = 1'b1;
        tick();
        ticks(8);
        chk("t2_held", 32'(bus.count), 32'd12);
        bus.start_req = 1'b1;
        tick();
        chk("t2_resume_no_reload", 32'(bus.count), 32'd12);
        tick();
        chk("t2_first_decrement", 32'(bus.count), 32'd11);

        // T3: restart mid-run and after expiry
        bus.clear_req = 1'b1;
        tick();
        bus.set_val = 6'd9;
        bus.start_req = 1'b1;
        tick();
        run_to(4);
        bus.restart_req = 1'b1;
        tick();
        chk("t3_restart_count", 32'(bus.count), 32'd9);
        chk("t3_restart_state", 32'(bus.state), 32'd1);
        run_to(0);
        ticks(3);
        bus.set_val = 6'd33;
        bus.restart_req = 1'b1;
        tick();
        chk("t3_restart_after_exp", 32'(bus.count), 32'd9);
        chk("t3_led_cleared", 32'(bus.led), 32'd0);

        // T4: simultaneous requests in RUN, serviced one per tick by priority
        bus.pause_req = 1'b1; bus.start_req = 1'b1; bus.clear_req = 1'b1;
        tick();
        chk("t4_clear_only", 32'({bus.clear_ack, bus.restart_ack, bus.pause_ack, bus.start_ack}), 32'b1000);
        chk("t4_idle", 32'(bus.state), 32'd0);
        tick();
        chk("t4_pause_ack", 32'(bus.pause_ack), 32'd1);
        tick();
        chk("t4_start_load", 32'(bus.count), 32'd33);
        ticks(3);

        // T5: zero load expires immediately
        bus.clear_req = 1'b1;
        tick();
        bus.set_val = 6'd0;
        bus.start_req = 1'b1;
        tick();
        chk("t5_expired", 32'(bus.state), 32'd3);
        ticks(4);

        // maximum load is legal
        bus.clear_req = 1'b1;
        tick();
        bus.set_val = 6'd63;
        bus.start_req = 1'b1;
        tick();
        chk("max_load", 32'(bus.count), 32'd63);
        tick();

        // T6: asynchronous reset while running at 30, pending start serviced after release
        bus.clear_req = 1'b1;
        tick();
        bus.set_val = 6'd40;
        bus.start_req = 1'b1;
        tick();
        run_to(30);
        #2;
        my_reset = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        bus.set_val = 6'd7;
        bus.start_req = 1'b1;
        @(posedge newclk); #1;
        check_reset_values();
        my_reset = 1'b0;
        tick();
        chk("t6_start_after_release", 32'(bus.count), 32'd7);
        ticks(2);

        // random requests and switch values
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.set_val = 6'($urandom_range(0, 63));
                    1: bus.set_val = 6'd0;
                    2: bus.set_val = 6'd63;
                    default: bus.set_val = 6'($urandom_range(1, 6));
                endcase
            end
            if ($urandom_range(0, 99) < 12) bus.start_req = 1'b1;
            if ($urandom_range(0, 99) < 5)  bus.pause_req = 1'b1;
            if ($urandom_range(0, 99) < 3)  bus.restart_req = 1'b1;
            if ($urandom_range(0, 99) < 2)  bus.clear_req = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
